// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the
// control unit (master) and the responder (slave).
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word data-memory responder: captures one access,
// waits WAIT_CYCLES, commits it and pulses ready.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic             CLK,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        commit;
  logic        bad;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign idx = addr_q[AW+1:2];
  assign bad = (|addr_q[1:0]) | (|addr_q[31:AW+2]);

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == S_RESP);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.err   = err_q;

  // Next state and commit strobe.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.req) state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Capture, wait countdown, error flag and read data.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            err_q <= bad;
            if (!bad && !we_q) rdata_q <= mem[idx];
          end
        end
        S_RESP: err_q <= 1'b0;
        default: err_q <= 1'b0;
      endcase
    end
  end

  // Storage array; a reset edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!reset && commit && !bad && we_q) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder,
// run with WAIT_CYCLES=2 and WAIT_CYCLES=0 side by side.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        solo;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mem_m [64];
  logic [31:0] rdata_m2;
  logic [31:0] rdata_m0;

  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  assign bus2.req   = req;
  assign bus2.we    = we;
  assign bus2.addr  = addr;
  assign bus2.wdata = wdata;
  assign bus0.req   = req & ~solo;
  assign bus0.we    = we;
  assign bus0.addr  = addr;
  assign bus0.wdata = wdata;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus2.slave)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus0.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd256);
  endfunction

  // One access on both DUTs; j counts negedges after E0.
  task automatic access(input bit w,
                        input logic [31:0] a,
                        input logic [31:0] d);
    bit bad;
    bad = is_bad(a);
    @(negedge CLK);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge CLK);
    req = 1'b0; we = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    if (!bad) begin
      if (w) mem_m[a/4] = d;
      else begin
        rdata_m2 = mem_m[a/4];
        rdata_m0 = mem_m[a/4];
      end
    end
    for (int j = 0; j <= 4; j++) begin
      if (j > 0) @(negedge CLK);
      check("ready_w2", 32'(bus2.ready), 32'(j == 3));
      check("ready_w0", 32'(bus0.ready), 32'(j == 1));
      check("busy_w2", 32'(bus2.busy), 32'(j <= 3));
      check("busy_w0", 32'(bus0.busy), 32'(j <= 1));
      if (j == 3) begin
        check("err_w2", 32'(bus2.err), 32'(bad));
        check("rdata_w2", bus2.rdata, rdata_m2);
      end
      if (j == 1) begin
        check("err_w0", 32'(bus0.err), 32'(bad));
        check("rdata_w0", bus0.rdata, rdata_m0);
      end
      if (j == 4) check("err_clr_w2", 32'(bus2.err), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] hold_addr [$];
    logic [31:0] a;
    logic [31:0] ea;
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    rdata_m2 = '0;
    rdata_m0 = '0;
    reset = 1'b1; req = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; solo = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    check("rst_ready", 32'(bus2.ready), 32'd0);
    check("rst_err", 32'(bus2.err), 32'd0);
    check("rst_busy", 32'(bus2.busy), 32'd0);
    check("rst_rdata", bus2.rdata, 32'd0);

    access(1'b0, 32'h0, 32'h0);
    access(1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b0, 32'h10, 32'h0);
    access(1'b1, 32'h12, 32'h1);
    access(1'b0, 32'h10, 32'h0);
    access(1'b0, 32'h100, 32'h0);
    access(1'b0, 32'hFC, 32'h0);
    access(1'b1, 32'hFC, 32'hA5A5_0001);
    access(1'b0, 32'hFC, 32'h0);

    // req held high on the WAIT_CYCLES=2 DUT only.
    solo = 1'b1;
    @(negedge CLK);
    for (int n = 0; n <= 25; n++) begin
      if (n > 0) @(negedge CLK);
      check("hold_ready", 32'(bus2.ready), 32'(n % 5 == 4));
      if (n % 5 == 4) begin
        ea = hold_addr.pop_front();
        rdata_m2 = mem_m[ea/4];
        check("hold_rdata", bus2.rdata, rdata_m2);
      end
      if (n < 25) begin
        req = 1'b1; we = 1'b0;
        a = 32'($urandom_range(0, 63)) * 4;
        addr = a; wdata = $urandom;
        if (n % 5 == 0) hold_addr.push_back(a);
      end else begin
        req = 1'b0;
      end
    end
    repeat (2) @(negedge CLK);
    check("hold_idle", 32'(bus2.busy), 32'd0);
    solo = 1'b0;

    // Reset during WAIT aborts the write.
    @(negedge CLK);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
    @(negedge CLK);
    req = 1'b0; reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    rdata_m2 = '0;
    rdata_m0 = '0;
    for (int j = 0; j < 4; j++) begin
      check("abort_rdy2", 32'(bus2.ready), 32'd0);
      check("abort_rdy0", 32'(bus0.ready), 32'd0);
      @(negedge CLK);
    end
    check("abort_rdata", bus2.rdata, 32'd0);
    access(1'b0, 32'h20, 32'h0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'($urandom_range(0, 255)) | 32'd1;
        1: a = 32'd256 + 32'($urandom_range(0, 63)) * 4;
        2: a = $urandom;
        default: a = 32'($urandom_range(0, 63)) * 4;
      endcase
      access(1'($urandom), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
